// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and the row/col-to-address helper for the result collector.
// Latency: none (declarations only).
// Backpressure: not applicable.
package conv_pkg;

  localparam int DATA_W  = 16;
  localparam int OUT_DIM = 5;
  localparam int OUT_N   = OUT_DIM * OUT_DIM;
  localparam int ADDR_W  = 5;
  localparam int RC_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Raster address of an output-map position.
  function automatic logic [ADDR_W-1:0] rc_to_addr(input logic [RC_W-1:0] row,
                                                   input logic [RC_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(OUT_DIM) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/conv_result_ram.sv
// 25x16 register file with one write port and one registered read port.
// Latency: read data valid one cycle after rd_en.
// Backpressure: none; rd_data holds its value while rd_en is low.
module conv_result_ram
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [OUT_N];

  // Storage array: contents are never reset, the collector's written-mask gates them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register: only the port register is reset so the output starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/conv_result_collector.sv
// Collects a serpentine-ordered 5x5 convolution result map and drains it in raster order.
// Latency: first word valid 1 cycle after entering DRAIN, then 1 word/clk with out_ready high.
// Backpressure: out_ready low holds out_data/out_last; input is dropped (ovf) while draining.
// Optional build macro CONV_RELU_EN clamps negative results to zero on write.
module conv_result_collector
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              ovf,
  output logic              short_frm
);

  state_t            state_q;
  logic [RC_W-1:0]   row_q;
  logic [RC_W-1:0]   col_q;
  logic [RC_W-1:0]   row_nxt;
  logic [RC_W-1:0]   col_nxt;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [OUT_N-1:0]  mask_q;
  logic              hit_q;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              last_xfer;
  logic              fetch;
  logic [DATA_W-1:0] rd_data;

  assign wr_en     = in_valid && (state_q != ST_DRAIN);
  assign wr_addr   = rc_to_addr(row_q, col_q);
  assign last_xfer = out_valid && out_ready && out_last;
  assign fetch     = (state_q == ST_DRAIN) && !last_xfer && (!out_valid || out_ready)
                     && (rd_ptr_q < ADDR_W'(OUT_N));
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = hit_q ? rd_data : '0;

`ifdef CONV_RELU_EN
  assign wr_data = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign wr_data = in_data;
`endif

  // Serpentine walk: even rows step right, odd rows step left, row advances at the edge.
  always_comb begin
    row_nxt = row_q;
    col_nxt = col_q;
    if (!row_q[0]) begin
      if (col_q == RC_W'(OUT_DIM - 1)) row_nxt = row_q + 3'd1;
      else                             col_nxt = col_q + 3'd1;
    end else begin
      if (col_q == '0) row_nxt = row_q + 3'd1;
      else             col_nxt = col_q - 3'd1;
    end
  end

  // Collector FSM with all control outputs and counters registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      wr_cnt_q  <= '0;
      rd_ptr_q  <= '0;
      mask_q    <= '0;
      hit_q     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
      short_frm <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            // Row/col sit at 0 here, so this sample lands in entry 0.
            state_q   <= ST_FILL;
            mask_q    <= OUT_N'(1);
            wr_cnt_q  <= ADDR_W'(1);
            row_q     <= row_nxt;
            col_q     <= col_nxt;
            ovf       <= 1'b0;
            short_frm <= 1'b0;
          end
        end

        ST_FILL: begin
          if (in_valid) begin
            mask_q[wr_addr] <= 1'b1;
            wr_cnt_q        <= wr_cnt_q + 5'd1;
            row_q           <= row_nxt;
            col_q           <= col_nxt;
          end
          // A finish coinciding with the 25th write is treated as a full frame.
          if ((in_valid && wr_cnt_q == ADDR_W'(OUT_N - 1)) || in_finish) begin
            state_q  <= ST_DRAIN;
            row_q    <= '0;
            col_q    <= '0;
            wr_cnt_q <= '0;
            rd_ptr_q <= '0;
            if (!(in_valid && wr_cnt_q == ADDR_W'(OUT_N - 1))) begin
              short_frm <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (in_valid) begin
            ovf <= 1'b1;
          end
          if (last_xfer) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_ptr_q  <= '0;
          end else if (fetch) begin
            out_valid <= 1'b1;
            out_last  <= (rd_ptr_q == ADDR_W'(OUT_N - 1));
            hit_q     <= mask_q[rd_ptr_q];
            rd_ptr_q  <= rd_ptr_q + 5'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  conv_result_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (fetch),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: full, backpressured, short, overflow,
// ReLU and mid-drain reset frames against hand-computed raster tables.
module tb_conv_result_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_finish = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        ovf;
  logic        short_frm;

  int checks = 0;
  int errors = 0;
  int last_cyc = 0;

  logic [15:0] vals_q [25];
  logic [15:0] exp_q  [25];

  localparam logic [15:0] FULL_EXP [25] = '{
    16'd1,  16'd2,  16'd3,  16'd4,  16'd5,
    16'd10, 16'd9,  16'd8,  16'd7,  16'd6,
    16'd11, 16'd12, 16'd13, 16'd14, 16'd15,
    16'd20, 16'd19, 16'd18, 16'd17, 16'd16,
    16'd21, 16'd22, 16'd23, 16'd24, 16'd25};

  conv_result_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_finish (in_finish),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .ovf       (ovf),
    .short_frm (short_frm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_full_vals();
    for (int i = 0; i < 25; i++) begin
      vals_q[i] = 16'(i + 1);
      exp_q[i]  = FULL_EXP[i];
    end
  endtask

  // Drive n strobes from vals_q, optionally followed by a finish pulse.
  task automatic send(input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("frame_start_ovf_clr", ovf, 0);
        check("frame_start_short_clr", short_frm, 0);
        check("frame_start_busy", busy, 1);
      end
      in_valid = 1'b1;
      in_data  = vals_q[i];
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_finish = fin;
    if (fin) begin
      @(negedge clk);
      in_finish = 1'b0;
    end
    check("drain_entry_no_valid_yet", out_valid, 0);
    check("drain_entry_busy", busy, 1);
  endtask

  // Consume stop_n words; mode 1 uses the ready pattern 1,0,0,1.
  task automatic drain(input int mode, input int stop_n, input bit inj);
    int k = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_dat = '0;
    logic prev_last = 1'b0;
    while (k < stop_n && cyc < 300) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      in_valid  = inj && (cyc == 3);
      in_data   = 16'h1234;
      if (cyc == 0) check("first_valid_latency", out_valid, 1);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_dat);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        check($sformatf("data_%0d", k), out_data, exp_q[k]);
        check($sformatf("last_%0d", k), out_last, (k == 24) ? 1 : 0);
        k++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_last  = out_last;
      cyc++;
    end
    in_valid = 1'b0;
    if (k < stop_n) check("drain_timeout_words", k, stop_n);
    last_cyc = cyc;
  endtask

  task automatic finish_drain_checks();
    @(negedge clk);
    check("post_drain_valid", out_valid, 0);
    check("post_drain_busy", busy, 0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_short", short_frm, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame, ready held high
    load_full_vals();
    send(25, 1'b0);
    drain(0, 25, 1'b0);
    check("full_throughput_cycles", last_cyc, 25);
    check("full_ovf", ovf, 0);
    check("full_short", short_frm, 0);
    finish_drain_checks();

    // Full frame with backpressure
    send(25, 1'b0);
    drain(1, 25, 1'b0);
    finish_drain_checks();
    out_ready = 1'b1;

    // Short frame: 7 strobes then finish
    for (int i = 0; i < 25; i++) exp_q[i] = 16'h0000;
    exp_q[0] = 16'd1; exp_q[1] = 16'd2; exp_q[2] = 16'd3; exp_q[3] = 16'd4;
    exp_q[4] = 16'd5; exp_q[8] = 16'd7; exp_q[9] = 16'd6;
    send(7, 1'b1);
    check("short_flag", short_frm, 1);
    drain(0, 25, 1'b0);
    finish_drain_checks();
    check("short_flag_sticky", short_frm, 1);

    // Overflow during drain
    load_full_vals();
    send(25, 1'b0);
    drain(0, 25, 1'b1);
    finish_drain_checks();
    check("ovf_flag", ovf, 1);
    check("ovf_short_clear", short_frm, 0);

    // ReLU short frame; also clears ovf at start
    for (int i = 0; i < 25; i++) exp_q[i] = 16'h0000;
    vals_q[0] = 16'h8001;
    vals_q[1] = 16'h7FFF;
`ifdef CONV_RELU_EN
    exp_q[0] = 16'h0000;
`else
    exp_q[0] = 16'h8001;
`endif
    exp_q[1] = 16'h7FFF;
    send(2, 1'b1);
    drain(0, 25, 1'b0);
    finish_drain_checks();
    check("relu_ovf_cleared", ovf, 0);

    // Reset mid-drain after 10 transfers
    load_full_vals();
    send(25, 1'b0);
    drain(0, 10, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", out_data, 0);
    rst_n = 1'b1;

    // Full frame after reset drains from address 0
    send(25, 1'b0);
    drain(0, 25, 1'b0);
    finish_drain_checks();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_result_collector.md
CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: in_valid  in  1  one-cycle result strobe from 3x3 convolution engine.
REQ-003 SHALL have: in_data  in  16  signed result, sampled when in_valid=1.
REQ-004 SHALL have: in_finish  in  1  engine end-of-frame pulse.
REQ-005 SHALL have: out_valid  out  1  output word available.
REQ-006 SHALL have: out_ready  in  1  consumer accepts word when out_valid=1.
REQ-007 SHALL have: out_data  out  16  raster-ordered result.
REQ-008 SHALL have: out_last  out  1  high with the 25th output word.
REQ-009 SHALL have: busy  out  1  high in FILL or DRAIN.
REQ-010 SHALL have: ovf  out  1  sticky: in_valid received while in DRAIN.
REQ-011 SHALL have: short_frm  out  1  sticky: in_finish received with fewer than 25 results.

Function
REQ-012 SHALL collect one 5x5 output map (25 words) per frame.
REQ-013 SHALL implement states IDLE, FILL, DRAIN.
REQ-014 IDLE->FILL SHALL occur on in_valid=1; that sample is stored as entry 0 in the same cycle.
REQ-015 Entering FILL SHALL clear the 25-bit written-mask, ovf and short_frm.
REQ-016 Input arrives in serpentine order: even rows (0,2,4) left-to-right, odd rows (1,3) right-to-left; write address SHALL be row*5+col, using row/col counters that reverse column direction per row.
REQ-017 FILL->DRAIN SHALL occur on the 25th accepted in_valid, or on in_finish, whichever comes first.
REQ-018 in_finish with fewer than 25 writes SHALL set short_frm; in_finish after the 25th write SHALL be ignored.
REQ-019 DRAIN SHALL emit addresses 0..24 in order; out_valid SHALL rise the cycle after entering DRAIN.
REQ-020 Positions not written in the frame SHALL be output as 16'h0000.
REQ-021 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0; a transfer occurs when both are high.
REQ-022 After the transfer with out_last=1, SHALL go to IDLE and deassert out_valid the next cycle.
REQ-023 in_valid in DRAIN SHALL be dropped and set ovf; in_valid in IDLE on the cycle DRAIN ends SHALL start a new frame normally.
REQ-024 Throughput SHALL be one word per clock when out_ready is held high.

Reset
REQ-025 rst_n low SHALL force IDLE, counters 0, written-mask 0, out_valid=0, out_last=0, out_data=0, busy=0, ovf=0, short_frm=0, at any time, including mid-FILL or mid-DRAIN.
REQ-026 Buffer contents SHALL NOT require reset; the written-mask gates the output.

Configuration
REQ-027 With CONV_RELU_EN defined, in_data with bit 15 set SHALL be stored as 16'h0000; otherwise it is stored unmodified.
REQ-028 Without CONV_RELU_EN, no clamping logic SHALL be present.

Structure
REQ-029 Shared package conv_pkg SHALL hold DATA_W=16, OUT_DIM=5, OUT_N=25 and the state encoding.
REQ-030 Storage SHALL be sub-module conv_result_ram: 25x16 registers, one write port and one registered read port.

Verification
REQ-031 Full frame: 25 strobes with values 1..25, out_ready=1 -> out_data 1,2,3,4,5,10,9,8,7,6,11..15,20..16,21..25; out_last on the 25th word; ovf=0, short_frm=0.
REQ-032 Backpressure: out_ready toggled 1,0,0,1 -> each word is held while out_ready=0, with no loss or duplication; 25 transfers total.
REQ-033 Short frame: 7 strobes (values 1..7) then in_finish -> short_frm=1; outputs 1..5, 0, 0, 0, 7, 6, then 15 zeros.
REQ-034 Overflow: in_valid with 16'h1234 during DRAIN -> ovf=1, drained data unchanged; ovf cleared at the next frame start.
REQ-035 ReLU (CONV_RELU_EN): input 16'h8001 at position 0 -> output 16'h0000; input 16'h7FFF -> 16'h7FFF; without the macro, 16'h8001 -> 16'h8001.
REQ-036 Reset mid-DRAIN after 10 transfers -> out_valid=0 and state IDLE next cycle; a following full frame drains correctly from address 0.
